// File: rtl/jt51_lin2exp_ser_pkg.sv
// Shared definitions for the jt51 linear-to-exponent serial DAC transmitter.
//
// Contents
//   MAN_W / EXP_W / WORD_W : mantissa, exponent and serial word widths
//   SLOT_W                 : width of the per-channel bit-slot counter
//   SLOT_MAN0 / SLOT_EXP0  : first mantissa slot / first exponent slot
//   SLOT_LAST              : final slot of a channel window
//   state_t                : transmitter FSM states
//   slot_in_window()       : true for slots that carry data (sh1/sh2 high)
//
// Build option: JT51_EXP0_ZERO_EN (used by jt51_lin2exp_ser_enc) makes an
// all-zero sample encode as exp=0, man=0.

package jt51_lin2exp_ser_pkg;

  localparam int MAN_W  = 10;
  localparam int EXP_W  = 3;
  localparam int WORD_W = MAN_W + EXP_W;
  localparam int SLOT_W = 4;

  localparam logic [SLOT_W-1:0] SLOT_MAN0 = 4'd3;
  localparam logic [SLOT_W-1:0] SLOT_EXP0 = 4'd13;
  localparam logic [SLOT_W-1:0] SLOT_LAST = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // Slots 0-2 are the silent lead-in; mantissa starts at SLOT_MAN0 and the
  // exponent follows from SLOT_EXP0 up to SLOT_LAST.
  function automatic logic slot_in_window(input logic [SLOT_W-1:0] slot);
    return (slot >= SLOT_MAN0) && (slot <= SLOT_LAST);
  endfunction

endpackage

// File: rtl/jt51_lin2exp_ser_enc.sv
// Combinational linear-to-floating encoder for one channel.
//
// The exponent is 7 minus the length of the run of sign-copies found in
// lin[14:9] (scanning from bit 14 downwards). The mantissa is the 10-bit
// window lin[exp+8 : exp-1]; lower bits are truncated, nothing is rounded
// or saturated.
//
// Ports
//   i_lin  in  16  signed linear sample
//   o_man  out 10  mantissa (two's complement)
//   o_exp  out 3   exponent, 1..7 (0 only for a zero sample, see below)
//
// Build option: JT51_EXP0_ZERO_EN -- when defined, lin==0 encodes as exp=0,
// man=0 so the decoder reconstructs a true zero. When undefined, lin==0
// follows the normal rule and yields exp=1, man=0.

module jt51_lin2exp_ser_enc
  import jt51_lin2exp_ser_pkg::*;
(
  input  logic [15:0]      i_lin,
  output logic [MAN_W-1:0] o_man,
  output logic [EXP_W-1:0] o_exp
);

  logic [2:0] w_run_len;
  logic       w_run;

  // Length of the leading sign-copy run in bits 14..9 (0..6).
  always_comb begin
    w_run     = 1'b1;
    w_run_len = 3'd0;
    for (int i = 14; i >= 9; i--) begin
      if (w_run && (i_lin[i] == i_lin[15])) begin
        w_run_len = w_run_len + 3'd1;
      end else begin
        w_run = 1'b0;
      end
    end
  end

  always_comb begin
    o_exp = 3'd7 - w_run_len;
`ifdef JT51_EXP0_ZERO_EN
    if (i_lin == 16'd0) begin
      o_exp = 3'd0;
    end
`endif
  end

  always_comb begin
    case (o_exp)
      3'd7:    o_man = i_lin[15:6];
      3'd6:    o_man = i_lin[14:5];
      3'd5:    o_man = i_lin[13:4];
      3'd4:    o_man = i_lin[12:3];
      3'd3:    o_man = i_lin[11:2];
      3'd2:    o_man = i_lin[10:1];
      3'd1:    o_man = i_lin[9:0];
      default: o_man = '0;
    endcase
  end

endmodule

// File: rtl/jt51_lin2exp_ser.sv
// Linear-to-floating serial DAC transmitter (YM3012-style stream).
//
// Accepts signed 16-bit L/R sample pairs through a one-deep holding
// register, encodes each channel to a 10-bit mantissa / 3-bit exponent and
// shifts both out LSB first, left channel framed by o_sh1 and right channel
// by o_sh2. One bit slot per i_cen pulse; 16 slots per channel.
//
// Ports
//   i_clk        in   1   system clock
//   i_rst        in   1   asynchronous active-high reset
//   i_cen        in   1   bit-slot clock enable
//   i_din_valid  in   1   i_l_in / i_r_in carry a new pair
//   o_din_ready  out  1   holding register free
//   i_l_in       in   16  signed left sample
//   i_r_in       in   16  signed right sample
//   o_so         out  1   serial data, LSB first
//   o_sh1        out  1   left-channel data window
//   o_sh2        out  1   right-channel data window
//   o_busy       out  1   frame in progress
//
// Build option: JT51_EXP0_ZERO_EN (see jt51_lin2exp_ser_enc) selects the
// exp=0 encoding of an all-zero sample.
//
// State table
//   state    | meaning
//   ST_IDLE  | no frame; outputs low, waiting for a full holding register
//   ST_LEFT  | shifting the left word, slots 0..15, o_sh1 in slots 3..15
//   ST_RIGHT | shifting the right word, slots 0..15, o_sh2 in slots 3..15

module jt51_lin2exp_ser
  import jt51_lin2exp_ser_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cen,
  input  logic        i_din_valid,
  output logic        o_din_ready,
  input  logic [15:0] i_l_in,
  input  logic [15:0] i_r_in,
  output logic        o_so,
  output logic        o_sh1,
  output logic        o_sh2,
  output logic        o_busy
);

  logic [15:0]       r_l_hold;
  logic [15:0]       r_r_hold;
  logic              r_full;
  state_t            r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [WORD_W-1:0] r_word_l;
  logic [WORD_W-1:0] r_word_r;

  logic [MAN_W-1:0]  w_man_l;
  logic [EXP_W-1:0]  w_exp_l;
  logic [MAN_W-1:0]  w_man_r;
  logic [EXP_W-1:0]  w_exp_r;
  logic              w_hs;
  state_t            w_state_nxt;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic              w_load;
  logic              w_so_nxt;
  logic              w_sh1_nxt;
  logic              w_sh2_nxt;

  jt51_lin2exp_ser_enc u_enc_l (
    .i_lin (r_l_hold),
    .o_man (w_man_l),
    .o_exp (w_exp_l)
  );

  jt51_lin2exp_ser_enc u_enc_r (
    .i_lin (r_r_hold),
    .o_man (w_man_r),
    .o_exp (w_exp_r)
  );

  assign o_din_ready = ~r_full;
  assign o_busy      = (r_state != ST_IDLE);
  assign w_hs        = i_din_valid & ~r_full;

  // Holding register. A handshake needs ~r_full and a load needs r_full, so
  // the two never coincide; the handshake branch still has priority so a
  // newly accepted pair always leaves r_full set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_full   <= 1'b0;
      r_l_hold <= '0;
      r_r_hold <= '0;
    end else if (w_hs) begin
      r_full   <= 1'b1;
      r_l_hold <= i_l_in;
      r_r_hold <= i_r_in;
    end else if (w_load) begin
      r_full   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // Next-state logic. The slot counter wraps 15 -> 0 naturally at each
  // channel boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_load      = 1'b0;
    if (i_cen) begin
      case (r_state)
        ST_IDLE: begin
          if (r_full) begin
            w_state_nxt = ST_LEFT;
            w_slot_nxt  = '0;
            w_load      = 1'b1;
          end
        end
        ST_LEFT: begin
          w_slot_nxt = r_slot + 4'd1;
          if (r_slot == SLOT_LAST) begin
            w_state_nxt = ST_RIGHT;
          end
        end
        ST_RIGHT: begin
          w_slot_nxt = r_slot + 4'd1;
          if (r_slot == SLOT_LAST) begin
            if (r_full) begin
              w_state_nxt = ST_LEFT;
              w_load      = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_slot_nxt  = '0;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_slot_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs are computed for the slot being entered and registered on the
  // same cen edge, so the pins always reflect the current (state, slot).
  always_comb begin
    w_sh1_nxt = (w_state_nxt == ST_LEFT)  && slot_in_window(w_slot_nxt);
    w_sh2_nxt = (w_state_nxt == ST_RIGHT) && slot_in_window(w_slot_nxt);
    w_so_nxt  = 1'b0;
    if (w_sh1_nxt) begin
      w_so_nxt = r_word_l[0];
    end else if (w_sh2_nxt) begin
      w_so_nxt = r_word_r[0];
    end
  end

  // Both words are captured at LEFT load so the right channel comes from the
  // same pair even if the holding register is refilled during LEFT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_so     <= 1'b0;
      o_sh1    <= 1'b0;
      o_sh2    <= 1'b0;
      r_word_l <= '0;
      r_word_r <= '0;
    end else if (i_cen) begin
      o_so  <= w_so_nxt;
      o_sh1 <= w_sh1_nxt;
      o_sh2 <= w_sh2_nxt;
      if (w_load) begin
        r_word_l <= {w_exp_l, w_man_l};
        r_word_r <= {w_exp_r, w_man_r};
      end else begin
        if (w_sh1_nxt) begin
          r_word_l <= r_word_l >> 1;
        end
        if (w_sh2_nxt) begin
          r_word_r <= r_word_r >> 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt51_lin2exp_ser.sv
module tb_jt51_lin2exp_ser;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_cen = 1'b0;
  logic        i_din_valid;
  logic        o_din_ready;
  logic [15:0] i_l_in;
  logic [15:0] i_r_in;
  logic        o_so;
  logic        o_sh1;
  logic        o_sh2;
  logic        o_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  jt51_lin2exp_ser dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_cen       (i_cen),
    .i_din_valid (i_din_valid),
    .o_din_ready (o_din_ready),
    .i_l_in      (i_l_in),
    .i_r_in      (i_r_in),
    .o_so        (o_so),
    .o_sh1       (o_sh1),
    .o_sh2       (o_sh2),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // cen generator: one pulse every cen_div clocks
  int cen_div = 1;
  int cdiv    = 0;
  always @(negedge clk) begin
    if (cen_div <= 1) begin
      i_cen = 1'b1;
    end else begin
      i_cen = (cdiv == 0);
      cdiv  = (cdiv + 1) % cen_div;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference encoder: smallest exponent e in 1..7 for which the sample fits
  // a (9+e)-bit signed range; mantissa is the sample arithmetically shifted
  // right by e-1 and kept to 10 bits.
  function automatic logic [12:0] model_enc(input logic [15:0] lin);
    int v;
    int e;
    logic [9:0] m;
    logic [2:0] e3;
    v = int'($signed(lin));
    e = 7;
    for (int k = 7; k >= 1; k--) begin
      if ((v >= -(1 << (8 + k))) && (v < (1 << (8 + k)))) e = k;
    end
`ifdef JT51_EXP0_ZERO_EN
    if (v == 0) e = 0;
`endif
    m  = (e == 0) ? 10'd0 : 10'(v >>> (e - 1));
    e3 = 3'(e);
    return {e3, m};
  endfunction

  // Decode (man << (exp-1), sign-extended); truncation error must lie in
  // [0, 2^(exp-1)).
  function automatic logic dec_ok(input logic [15:0] lin, input logic [12:0] w);
    int v, mi, e, dec, err, bound;
    v     = int'($signed(lin));
    mi    = int'($signed(w[9:0]));
    e     = int'(w[12:10]);
    dec   = (e == 0) ? 0 : (mi * (1 << (e - 1)));
    bound = (e == 0) ? 1 : (1 << (e - 1));
    err   = v - dec;
    return (err >= 0) && (err < bound);
  endfunction

  // Serial stream monitor: rebuilds words from so while sh1/sh2 are high.
  int          slot_idx = 0;
  int          l_n = 0, r_n = 0, badlen = 0, stray = 0;
  logic [12:0] l_w = '0, r_w = '0;
  logic [12:0] ql[$];
  logic [12:0] qr[$];
  int          rise_l[$];
  int          rise_r[$];
  logic        prev_sh1 = 1'b0, prev_sh2 = 1'b0;

  always @(posedge clk) begin
    if (!i_rst && i_cen) begin
      #1;
      slot_idx++;
      if (o_sh1) begin
        if (!prev_sh1) rise_l.push_back(slot_idx);
        if (l_n < 13) l_w[l_n] = o_so;
        l_n++;
      end else if (l_n != 0) begin
        ql.push_back(l_w);
        if (l_n != 13) badlen++;
        l_n = 0;
        l_w = '0;
      end
      if (o_sh2) begin
        if (!prev_sh2) rise_r.push_back(slot_idx);
        if (r_n < 13) r_w[r_n] = o_so;
        r_n++;
      end else if (r_n != 0) begin
        qr.push_back(r_w);
        if (r_n != 13) badlen++;
        r_n = 0;
        r_w = '0;
      end
      if (!o_sh1 && !o_sh2 && o_so) stray++;
      if (o_sh1 && o_sh2) stray++;
      prev_sh1 = o_sh1;
      prev_sh2 = o_sh2;
    end
  end

  task automatic mon_clear();
    ql.delete();
    qr.delete();
    rise_l.delete();
    rise_r.delete();
    l_n = 0; r_n = 0; l_w = '0; r_w = '0;
    badlen = 0; stray = 0;
    prev_sh1 = 1'b0; prev_sh2 = 1'b0;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int n;
    n = 0;
    @(negedge clk);
    i_din_valid = 1'b1;
    i_l_in      = l;
    i_r_in      = r;
    while (!o_din_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("hs_timeout", 32'(n < 2000), 32'd1);
    @(posedge clk);
    #1;
    i_din_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (qr.size() < n && k < 6000) begin
      @(negedge clk);
      k++;
    end
    chk("frame_timeout", 32'(qr.size() >= n), 32'd1);
  endtask

  // Single directed pair with cen on every clock.
  task automatic run_pair(input logic [15:0] l, input logic [15:0] r,
                          input logic [12:0] exp_l, input logic [12:0] exp_r,
                          input string tag);
    int lat;
    cen_div = 1;
    @(negedge clk);
    mon_clear();
    send(l, r);
    lat = 0;
    while (!o_sh1 && lat < 40) begin
      @(posedge clk);
      #1;
      if (i_cen) lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    wait_frames(1);
    repeat (4) @(negedge clk);
    chk({tag, "_L"}, 32'(ql.size() > 0 ? ql[0] : 13'h1fff), 32'(exp_l));
    chk({tag, "_R"}, 32'(qr.size() > 0 ? qr[0] : 13'h1fff), 32'(exp_r));
    chk({tag, "_sh_gap"},
        32'((rise_l.size() > 0 && rise_r.size() > 0) ? rise_r[0] - rise_l[0] : -1), 32'd16);
    chk({tag, "_winlen"}, 32'(badlen), 32'd0);
    chk({tag, "_stray"}, 32'(stray), 32'd0);
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  logic [15:0] pl[$];
  logic [15:0] pr[$];

  initial begin
    logic [15:0] l, r;
    i_rst       = 1'b1;
    i_din_valid = 1'b0;
    i_l_in      = '0;
    i_r_in      = '0;
    repeat (3) @(negedge clk);
    chk("rst_so",    32'(o_so),        32'd0);
    chk("rst_sh1",   32'(o_sh1),       32'd0);
    chk("rst_sh2",   32'(o_sh2),       32'd0);
    chk("rst_busy",  32'(o_busy),      32'd0);
    chk("rst_ready", 32'(o_din_ready), 32'd1);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(o_busy), 32'd0);

    run_pair(16'h4000, 16'h0123, {3'd7, 10'h100}, {3'd1, 10'h123}, "p4000");
    run_pair(16'hFFFF, 16'h0800, {3'd1, 10'h3FF}, {3'd4, 10'h100}, "pFFFF");
`ifdef JT51_EXP0_ZERO_EN
    run_pair(16'h0000, 16'h0000, {3'd0, 10'h000}, {3'd0, 10'h000}, "zero");
`else
    run_pair(16'h0000, 16'h0000, {3'd1, 10'h000}, {3'd1, 10'h000}, "zero");
`endif

    // Continuous random stream, cen every third clock.
    cen_div = 3;
    @(negedge clk);
    mon_clear();
    for (int i = 0; i < 16; i++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      l = 16'($signed(l) >>> $urandom_range(0, 14));
      r = 16'($signed(r) >>> $urandom_range(0, 14));
      pl.push_back(l);
      pr.push_back(r);
      send(l, r);
    end
    wait_frames(16);
    repeat (10) @(negedge clk);
    chk("rnd_nL", 32'(ql.size()), 32'd16);
    chk("rnd_nR", 32'(qr.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < ql.size() && i < qr.size()) begin
        chk("rnd_L", 32'(ql[i]), 32'(model_enc(pl[i])));
        chk("rnd_R", 32'(qr[i]), 32'(model_enc(pr[i])));
        chk("rnd_Lerr", 32'(dec_ok(pl[i], ql[i])), 32'd1);
        chk("rnd_Rerr", 32'(dec_ok(pr[i], qr[i])), 32'd1);
      end
    end
    for (int i = 1; i < rise_l.size(); i++) begin
      chk("rnd_gapless", 32'(rise_l[i] - rise_l[i-1]), 32'd32);
    end
    chk("rnd_winlen", 32'(badlen), 32'd0);
    chk("rnd_stray", 32'(stray), 32'd0);

    // Reset in LEFT slot 8 with a second pair pending.
    cen_div = 1;
    @(negedge clk);
    mon_clear();
    send(16'h0020, 16'h0155);
    send(16'h1234, 16'h4321);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_sh1",   32'(o_sh1),       32'd1);
    chk("pre_rst_so",    32'(o_so),        32'd1);
    chk("pre_rst_ready", 32'(o_din_ready), 32'd0);
    chk("pre_rst_busy",  32'(o_busy),      32'd1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_so",    32'(o_so),        32'd0);
    chk("mid_rst_sh1",   32'(o_sh1),       32'd0);
    chk("mid_rst_sh2",   32'(o_sh2),       32'd0);
    chk("mid_rst_busy",  32'(o_busy),      32'd0);
    chk("mid_rst_ready", 32'(o_din_ready), 32'd1);
    @(negedge clk);
    mon_clear();
    i_rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 32'(o_busy), 32'd0);
    send(16'h8000, 16'h7FFF);
    wait_frames(1);
    repeat (100) @(negedge clk);
    chk("post_rst_nL", 32'(ql.size()), 32'd1);
    chk("post_rst_nR", 32'(qr.size()), 32'd1);
    chk("post_rst_L", 32'(ql.size() > 0 ? ql[0] : 13'h1fff), 32'(model_enc(16'h8000)));
    chk("post_rst_R", 32'(qr.size() > 0 ? qr[0] : 13'h1fff), 32'(model_enc(16'h7FFF)));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
